// File: rtl/block_encryptor_cbc_stream_pkg.sv
// Shared definitions for the CBC nibble-stream encryptor and its decryptor.
// State encoding, widths and the nibble cipher live here.
package block_encryptor_cbc_stream_pkg;

    localparam int NIB_W  = 4;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HI   = 2'd1,
        LO   = 2'd2,
        OUT  = 2'd3
    } state_e;

    // Self-inverse, so the decryptor applies the same function.
    function automatic logic [NIB_W-1:0] e_k(
        input logic [NIB_W-1:0] x,
        input logic [NIB_W-1:0] key
    );
        return x ^ key;
    endfunction

endpackage

// File: rtl/block_encryptor_cbc_stream_nibble_cipher_enc.sv
// Nibble cipher datapath, shared by the HI and LO steps of the encryptor.
module nibble_cipher_enc
    import block_encryptor_cbc_stream_pkg::*;
(
    input  logic [NIB_W-1:0] x,
    input  logic [NIB_W-1:0] k,
    output logic [NIB_W-1:0] y
);

    assign y = e_k(x, k);

endmodule

// File: rtl/block_encryptor_cbc_stream.sv
// Byte-wide CBC encryptor built from a 4-bit cipher, one nibble per cycle.
// Optional block counter port under BLOCK_ENCRYPTOR_CBC_BLKCNT_EN.
module block_encryptor_cbc_stream
    import block_encryptor_cbc_stream_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sop,
    input  logic [BYTE_W-1:0] p,
    input  logic [NIB_W-1:0]  k,
    input  logic [NIB_W-1:0]  iv,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] c
`ifdef BLOCK_ENCRYPTOR_CBC_BLKCNT_EN
    ,
    output logic [15:0]       blk_cnt
`endif
);

    state_e            state_q, state_d;
    logic [BYTE_W-1:0] p_q, p_d;
    logic [NIB_W-1:0]  k_q, k_d;
    logic [NIB_W-1:0]  ch_q, ch_d;
    logic [BYTE_W-1:0] c_q, c_d;
    logic [NIB_W-1:0]  ciph_x, ciph_y;
    logic              accept;

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign c         = c_q;
    assign accept    = in_valid & in_ready;

    // HI chains from ch, LO chains from the high ciphertext nibble.
    assign ciph_x = (state_q == HI) ? (p_q[7:4] ^ ch_q)
                                    : (p_q[3:0] ^ c_q[7:4]);

    nibble_cipher_enc u_cipher (
        .x (ciph_x),
        .k (k_q),
        .y (ciph_y)
    );

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        k_d     = k_q;
        ch_d    = ch_q;
        c_d     = c_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    p_d     = p;
                    k_d     = k;
                    if (in_sop) ch_d = iv;
                    state_d = HI;
                end
            end
            HI: begin
                c_d[7:4] = ciph_y;
                state_d  = LO;
            end
            LO: begin
                c_d[3:0] = ciph_y;
                ch_d     = ciph_y;
                state_d  = OUT;
            end
            OUT: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            p_q     <= '0;
            k_q     <= '0;
            ch_q    <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            k_q     <= k_d;
            ch_q    <= ch_d;
            c_q     <= c_d;
        end
    end

`ifdef BLOCK_ENCRYPTOR_CBC_BLKCNT_EN
    logic [15:0] blk_cnt_q, blk_cnt_d;

    always_comb begin
        blk_cnt_d = blk_cnt_q;
        if (out_valid && out_ready) blk_cnt_d = blk_cnt_q + 16'd1;
        if (accept && in_sop)       blk_cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) blk_cnt_q <= '0;
        else       blk_cnt_q <= blk_cnt_d;
    end

    assign blk_cnt = blk_cnt_q;
`endif

endmodule

// File: tb/tb_block_encryptor_cbc_stream.sv
// Directed bench for block_encryptor_cbc_stream: vector table plus
// backpressure, mid-flight reset, round trip and optional counter sequences.
module tb_block_encryptor_cbc_stream;
    import block_encryptor_cbc_stream_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic       in_sop;
    logic [7:0] p;
    logic [3:0] k;
    logic [3:0] iv;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] c;
`ifdef BLOCK_ENCRYPTOR_CBC_BLKCNT_EN
    logic [15:0] blk_cnt;
`endif

    always #5 clk = ~clk;

    block_encryptor_cbc_stream dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sop    (in_sop),
        .p         (p),
        .k         (k),
        .iv        (iv),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c)
`ifdef BLOCK_ENCRYPTOR_CBC_BLKCNT_EN
        ,
        .blk_cnt   (blk_cnt)
`endif
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic       sop;
        logic [7:0] p;
        logic [3:0] k;
        logic [3:0] iv;
        logic [7:0] exp_c;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one byte, scrambles inputs after acceptance, and returns
    // the number of edges from presentation to out_valid.
    task automatic send(input logic sop, input logic [7:0] pv,
                        input logic [3:0] kv, input logic [3:0] ivv,
                        output logic [7:0] cv, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            tick();
            w++;
        end
        if (!in_ready) chk("in_ready wait timeout", 16'd0, 16'd1);
        in_valid = 1'b1;
        in_sop   = sop;
        p        = pv;
        k        = kv;
        iv       = ivv;
        lat      = 0;
        do begin
            tick();
            lat++;
            if (lat == 1) begin
                in_valid = 1'b0;
                in_sop   = ~sop;
                p        = ~pv;
                k        = ~kv;
                iv       = ~ivv;
            end
        end while (!out_valid && lat < 10);
        if (!out_valid) chk("out_valid wait timeout", 16'd0, 16'd1);
        cv = c;
    endtask

    initial begin
        logic [7:0] cv;
        int         lat;
        logic [3:0] rk, riv, ch;
        logic [7:0] pt[16];
        logic [7:0] ct[16];
        logic [3:0] ph, pl;

        tbl[0] = '{1'b1, 8'h33, 4'hB, 4'h9, 8'h19};
        tbl[1] = '{1'b0, 8'h00, 4'hB, 4'h0, 8'h29};
        tbl[2] = '{1'b1, 8'h33, 4'hB, 4'h9, 8'h19};
        tbl[3] = '{1'b0, 8'hA5, 4'h0, 4'h0, 8'h36};
        tbl[4] = '{1'b0, 8'hFF, 4'hF, 4'h3, 8'h66};
        tbl[5] = '{1'b1, 8'h00, 4'h0, 4'h0, 8'h00};
        tbl[6] = '{1'b0, 8'h12, 4'h5, 4'hC, 8'h43};
        tbl[7] = '{1'b1, 8'hC7, 4'hA, 4'hF, 8'h94};
        tbl[8] = '{1'b0, 8'h80, 4'h1, 4'h6, 8'hDC};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        p         = '0;
        k         = '0;
        iv        = '0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("reset in_ready", {15'd0, in_ready}, 16'd1);
        chk("reset out_valid", {15'd0, out_valid}, 16'd0);
        chk("reset c", {8'd0, c}, 16'd0);

        // Table: out_ready held high, also outside OUT
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            send(tbl[i].sop, tbl[i].p, tbl[i].k, tbl[i].iv, cv, lat);
            chk($sformatf("vec%0d c", i), {8'd0, cv}, {8'd0, tbl[i].exp_c});
            chk($sformatf("vec%0d latency", i), lat[15:0], 16'd3);
            tick();
            chk($sformatf("vec%0d back to idle", i),
                {14'd0, in_ready, out_valid}, 16'b10);
        end

        // Backpressure with a competing byte offered during OUT
        out_ready = 1'b0;
        send(1'b1, 8'h33, 4'hB, 4'h9, cv, lat);
        chk("bp first c", {8'd0, cv}, 16'h19);
        in_valid = 1'b1;
        in_sop   = 1'b1;
        p        = 8'h55;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp%0d c stable", i), {8'd0, c}, 16'h19);
            chk($sformatf("bp%0d in_ready", i), {15'd0, in_ready}, 16'd0);
            chk($sformatf("bp%0d out_valid", i), {15'd0, out_valid}, 16'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp release", {14'd0, in_ready, out_valid}, 16'b10);
        out_ready = 1'b0;

        // Reset while in LO with a freshly loaded chain of 7
        in_valid = 1'b1;
        in_sop   = 1'b1;
        p        = 8'h33;
        k        = 4'hB;
        iv       = 4'h7;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst mid out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst mid in_ready", {15'd0, in_ready}, 16'd1);
        chk("rst mid c", {8'd0, c}, 16'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rst no output %0d", i), {15'd0, out_valid}, 16'd0);
        end
        send(1'b0, 8'h00, 4'h0, 4'h0, cv, lat);
        chk("rst chain cleared", {8'd0, cv}, 16'h00);
        tick();

        // Round trip through a reference CBC decryptor
        rk  = 4'($urandom_range(0, 15));
        riv = 4'($urandom_range(0, 15));
        for (int i = 0; i < 16; i++) begin
            pt[i] = 8'($urandom_range(0, 255));
            send(i == 0, pt[i], rk, riv, ct[i], lat);
            tick();
        end
        ch = riv;
        for (int i = 0; i < 16; i++) begin
            ph = e_k(ct[i][7:4], rk) ^ ch;
            pl = e_k(ct[i][3:0], rk) ^ ct[i][7:4];
            ch = ct[i][3:0];
            chk($sformatf("roundtrip%0d", i), {8'd0, ph, pl}, {8'd0, pt[i]});
        end

`ifdef BLOCK_ENCRYPTOR_CBC_BLKCNT_EN
        for (int i = 0; i < 3; i++) begin
            send(i == 0, 8'h10 + 8'(i), 4'h3, 4'h4, cv, lat);
            tick();
        end
        chk("blk_cnt three", blk_cnt, 16'd3);
        out_ready = 1'b0;
        send(1'b1, 8'h42, 4'h1, 4'h2, cv, lat);
        chk("blk_cnt sop clear", blk_cnt, 16'd0);
        out_ready = 1'b1;
        tick();
        chk("blk_cnt after sop byte", blk_cnt, 16'd1);
        out_ready = 1'b0;
        send(1'b0, 8'h42, 4'h1, 4'h2, cv, lat);
        force dut.blk_cnt_q = 16'hFFFF;
        tick();
        release dut.blk_cnt_q;
        out_ready = 1'b1;
        tick();
        chk("blk_cnt wrap", blk_cnt, 16'h0000);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/block_encryptor_cbc_stream.md
BLOCK_ENCRYPTOR_CBC_STREAM -- requirements
Module: block_encryptor_cbc_stream

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
- clk  input  1  sole clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
REQ-002 The block SHALL expose these data-input ports:
- in_valid  input  1  plaintext byte offered.
- in_ready  output  1  block accepts a byte this cycle.
- in_sop  input  1  byte is the first of a message; the chain reloads from iv.
- p  input  8  plaintext byte; p[7:4] is the high nibble, p[3:0] the low nibble.
- k  input  4  key, sampled with the byte.
- iv  input  4  initialisation vector, sampled only when in_sop=1.
REQ-003 The block SHALL expose these data-output ports:
- out_valid  output  1  ciphertext byte available.
- out_ready  input  1  consumer accepts the byte.
- c  output  8  ciphertext byte.

Function
REQ-004 The nibble cipher SHALL be E_k(x) = x XOR k, 4-bit.
REQ-005 Per byte, with chain register ch:
- c[7:4] = E_k(p[7:4] XOR ch_in);
- c[3:0] = E_k(p[3:0] XOR c[7:4]);
- ch_in = iv if in_sop=1, otherwise the c[3:0] of the previous byte.
REQ-006 ch SHALL persist across bytes until reset or the next in_sop.
REQ-007 The FSM SHALL have states IDLE, HI, LO and OUT, with these transitions:
- IDLE -> HI on in_valid (the handshake).
- HI -> LO unconditionally.
- LO -> OUT unconditionally.
- OUT -> IDLE when out_ready=1.
REQ-008 in_ready SHALL be 1 only in IDLE, and a byte SHALL be accepted only when in_valid and in_ready are both 1.
- On accept, the block captures p and k.
- On accept, if in_sop=1 the block also loads ch with iv.
REQ-009 HI SHALL compute and register c[7:4]; LO SHALL compute and register c[3:0] and update ch with it.
REQ-010 out_valid SHALL be 1 only in OUT, and c SHALL be held stable while out_valid=1 and out_ready=0.
REQ-011 Latency SHALL be exactly 3 cycles: a byte accepted at edge N has out_valid=1 after edge N+3.
REQ-012 With out_ready held at 1, peak throughput SHALL be one byte per 4 cycles.
REQ-013 Changes to p, k, iv or in_sop after acceptance SHALL NOT affect the byte in flight.
REQ-014 in_sop SHALL be ignored while in_valid=0 or in_ready=0.
REQ-015 out_ready asserted outside OUT SHALL have no effect.

Reset
REQ-016 Reset SHALL drive the FSM to IDLE and clear c, ch, the captured p and the captured k to 0.
- After reset, in_ready=1 and out_valid=0.
REQ-017 Reset asserted in any state SHALL discard the byte in flight, with no output produced.
REQ-018 Reset SHALL take priority over every handshake event in the same cycle.

Configuration
REQ-019 Macro BLOCK_ENCRYPTOR_CBC_BLKCNT_EN SHALL gate an extra output port, blk_cnt (output, 16 bits).
- With the macro defined: blk_cnt increments on each completed output handshake (out_valid and out_ready both 1).
- blk_cnt wraps 0xFFFF -> 0x0000.
- blk_cnt clears on reset and on accept of an in_sop byte.
- Without the macro: the port and counter are absent, and all other behaviour is identical.

Structure
REQ-020 A shared package SHALL hold:
- the FSM state enumeration (IDLE, HI, LO, OUT);
- the nibble width constant (4) and the byte width constant (8);
- the nibble-cipher function E_k, so the matching decryptor uses the same definition.
REQ-021 The block SHALL contain one sub-module, nibble_cipher_enc (x, k -> y), instantiated once and shared by HI and LO.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Single byte: k=11, iv=9, p=0x33, in_sop=1 -> c=0x19 (decimal 25), out_valid after 3 cycles.
- Chaining: the next byte p=0x00 with in_sop=0 -> c=0x29; then a new message with in_sop=1, iv=9, p=0x33 -> c=0x19 again.
- Backpressure: out_ready=0 for 5 cycles in OUT -> c stable, in_ready=0, no second byte accepted; out_ready=1 -> return to IDLE next cycle.
- Reset mid-flight: reset asserted in state LO -> next cycle out_valid=0, in_ready=1, ch=0, no output produced.
- Round trip: 16 random bytes fed to this block, then to the existing CBC decryptor with the same k and iv -> plaintext recovered exactly.
- BLOCK_ENCRYPTOR_CBC_BLKCNT_EN defined: 3 bytes -> blk_cnt=3; an in_sop byte -> blk_cnt clears to 0; preload 0xFFFF -> next handshake gives 0x0000.
